// File: rtl/clint_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : clint_timer_if
// Description : Data-bus access interface for the CLINT machine timer.
//               The master drives request, write enable, address, write data
//               and byte strobes; the slave returns read data and a one-cycle
//               completion pulse.
// Revision    : 1.0 - initial release
// ============================================================================
interface clint_timer_if;
  logic        I_req;
  logic        I_we;
  logic [31:0] I_addr;
  logic [31:0] I_data;
  logic [3:0]  I_mask;
  logic [31:0] O_data;
  logic        O_ready;

  modport master (
    output I_req,
    output I_we,
    output I_addr,
    output I_data,
    output I_mask,
    input  O_data,
    input  O_ready
  );

  modport slave (
    input  I_req,
    input  I_we,
    input  I_addr,
    input  I_data,
    input  I_mask,
    output O_data,
    output O_ready
  );
endinterface
`default_nettype wire

// File: rtl/clint_timer.sv
`default_nettype none
// ============================================================================
// Module      : clint_timer
// Description : RISC-V CLINT-style machine timer. A 64-bit mtime counter runs
//               while ctrl.enable is set and raises a registered machine
//               timer interrupt whenever mtime >= mtimecmp (unsigned).
//               Registers are reached over a simple request/ready data bus
//               that completes one access every two cycles.
//               Optional feature macro: TIMER_PRESCALE_EN adds a prescale
//               register at offset 0x14 that divides the tick rate; without
//               it mtime advances every cycle and 0x14 reads as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module clint_timer #(
  parameter int unsigned RST_ENABLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  clint_timer_if.slave bus,
  output logic         O_timer_int
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic        c_rst_enable   = (RST_ENABLE != 0);
  localparam logic [63:0] c_mtimecmp_rst = {64{1'b1}};

  localparam logic [2:0] c_idx_mtime_lo = 3'd0;
  localparam logic [2:0] c_idx_mtime_hi = 3'd1;
  localparam logic [2:0] c_idx_cmp_lo   = 3'd2;
  localparam logic [2:0] c_idx_cmp_hi   = 3'd3;
  localparam logic [2:0] c_idx_ctrl     = 3'd4;
  localparam logic [2:0] c_idx_prescale = 3'd5;

  // --------------------------------------------------------------------------
  // Bus handshake FSM: IDLE accepts a request, RESP is the completion cycle.
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   w_accept;

  // State register; reset drops any pending completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: a request is taken only while no completion is pending.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.I_req) begin
          w_accept     = 1'b1;
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.O_ready = (r_state == ST_RESP);

  // --------------------------------------------------------------------------
  // Address decode. Only word index [4:2] matters; other address bits are
  // deliberately ignored.
  // --------------------------------------------------------------------------
  logic [2:0] w_idx;
  logic       w_wr;
  logic       w_wr_mtime_lo;
  logic       w_wr_mtime_hi;
  logic       w_wr_cmp_lo;
  logic       w_wr_cmp_hi;
  logic       w_wr_ctrl;
  logic       w_unused_addr;

  assign w_idx         = bus.I_addr[4:2];
  assign w_unused_addr = ^{bus.I_addr[31:5], bus.I_addr[1:0]};

  // A write with no strobes set completes but changes nothing, so it is not
  // treated as a write at all (and therefore does not stall mtime either).
  assign w_wr          = w_accept & bus.I_we & (|bus.I_mask);
  assign w_wr_mtime_lo = w_wr & (w_idx == c_idx_mtime_lo);
  assign w_wr_mtime_hi = w_wr & (w_idx == c_idx_mtime_hi);
  assign w_wr_cmp_lo   = w_wr & (w_idx == c_idx_cmp_lo);
  assign w_wr_cmp_hi   = w_wr & (w_idx == c_idx_cmp_hi);
  assign w_wr_ctrl     = w_wr & (w_idx == c_idx_ctrl);

  // Byte-lane merge of write data into an existing word.
  function automatic logic [31:0] f_merge(
    input logic [31:0] old_word,
    input logic [31:0] new_word,
    input logic [3:0]  mask
  );
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

  // --------------------------------------------------------------------------
  // Architectural registers
  // --------------------------------------------------------------------------
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_enable;
  logic [63:0] w_mtime_next;
  logic        w_tick;
  logic [31:0] w_prescale_rd;

  // --------------------------------------------------------------------------
  // Tick generation
  // --------------------------------------------------------------------------
`ifdef TIMER_PRESCALE_EN
  logic [31:0] r_prescale;
  logic [31:0] r_pcnt;
  logic        w_wr_prescale;

  assign w_wr_prescale = w_wr & (w_idx == c_idx_prescale);
  assign w_tick        = (r_pcnt == r_prescale);
  assign w_prescale_rd = r_prescale;

  // Prescale register and divider counter; reprogramming restarts the period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prescale <= 32'd0;
      r_pcnt     <= 32'd0;
    end else begin
      if (w_wr_prescale) begin
        r_prescale <= f_merge(r_prescale, bus.I_data, bus.I_mask);
        r_pcnt     <= 32'd0;
      end else if (w_tick) begin
        r_pcnt     <= 32'd0;
      end else begin
        r_pcnt     <= r_pcnt + 32'd1;
      end
    end
  end
`else
  assign w_tick        = 1'b1;
  assign w_prescale_rd = 32'd0;
`endif

  // mtime next value: a software write wins over the tick for the whole
  // cycle; otherwise a full 64-bit increment carries lo into hi at once.
  always_comb begin
    w_mtime_next = r_mtime;
    if (w_wr_mtime_lo || w_wr_mtime_hi) begin
      if (w_wr_mtime_lo) begin
        w_mtime_next[31:0] = f_merge(r_mtime[31:0], bus.I_data, bus.I_mask);
      end
      if (w_wr_mtime_hi) begin
        w_mtime_next[63:32] = f_merge(r_mtime[63:32], bus.I_data, bus.I_mask);
      end
    end else if (r_enable && w_tick) begin
      w_mtime_next = r_mtime + 64'd1;
    end
  end

  // mtime register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mtime <= 64'd0;
    end else begin
      r_mtime <= w_mtime_next;
    end
  end

  // mtimecmp register, written word by word with byte strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mtimecmp <= c_mtimecmp_rst;
    end else begin
      if (w_wr_cmp_lo) begin
        r_mtimecmp[31:0] <= f_merge(r_mtimecmp[31:0], bus.I_data, bus.I_mask);
      end
      if (w_wr_cmp_hi) begin
        r_mtimecmp[63:32] <= f_merge(r_mtimecmp[63:32], bus.I_data, bus.I_mask);
      end
    end
  end

  // ctrl.enable lives in byte lane 0 only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_enable <= c_rst_enable;
    end else if (w_wr_ctrl && bus.I_mask[0]) begin
      r_enable <= bus.I_data[0];
    end
  end

  // --------------------------------------------------------------------------
  // Read path: contents sampled at the acceptance edge, before any update.
  // --------------------------------------------------------------------------
  logic [31:0] w_rdata;
  logic [31:0] r_rdata;

  // Register read multiplexer; reserved offsets return zero.
  always_comb begin
    w_rdata = 32'd0;
    case (w_idx)
      c_idx_mtime_lo: w_rdata = r_mtime[31:0];
      c_idx_mtime_hi: w_rdata = r_mtime[63:32];
      c_idx_cmp_lo:   w_rdata = r_mtimecmp[31:0];
      c_idx_cmp_hi:   w_rdata = r_mtimecmp[63:32];
      c_idx_ctrl:     w_rdata = {31'd0, r_enable};
      c_idx_prescale: w_rdata = w_prescale_rd;
      default:        w_rdata = 32'd0;
    endcase
  end

  // Read data register: valid only in the completion cycle, zero otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= 32'd0;
    end else if (w_accept) begin
      r_rdata <= w_rdata;
    end else begin
      r_rdata <= 32'd0;
    end
  end

  assign bus.O_data = r_rdata;

  // --------------------------------------------------------------------------
  // Machine timer interrupt, registered compare of the current values.
  // --------------------------------------------------------------------------
  logic r_timer_int;

  // Interrupt follows the compare result with one cycle of latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timer_int <= 1'b0;
    end else begin
      r_timer_int <= (r_mtime >= r_mtimecmp);
    end
  end

  assign O_timer_int = r_timer_int;

endmodule
`default_nettype wire
